// File: rtl/indicator_pkg.sv
// ---------------------------------------------------------------------------
// indicator_pkg
// Shared definitions for the turn-indicator sequencer: FSM state encoding,
// one-hot car-state constants, request encodings and the request-source
// selection helper.
//
// Optional feature macro: TURN_HAZARD_EN (adds the HAZARD state).
// ---------------------------------------------------------------------------
package indicator_pkg;

`ifdef TURN_HAZARD_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } fsm_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } fsm_state_t;
`endif

    // One-hot car states
    localparam logic [3:0] CAR_UNSTARTED   = 4'b0001;
    localparam logic [3:0] CAR_STARTING    = 4'b0010;
    localparam logic [3:0] CAR_MOVING      = 4'b0100;
    localparam logic [3:0] CAR_POWERED_OFF = 4'b1000;

    // Turn request encodings, [1]=left, [0]=right
    localparam logic [1:0] REQ_NONE  = 2'b00;
    localparam logic [1:0] REQ_RIGHT = 2'b01;
    localparam logic [1:0] REQ_LEFT  = 2'b10;

    // Request source select
    localparam logic [1:0] SRC_NONE   = 2'b00;
    localparam logic [1:0] SRC_MANUAL = 2'b01;

    // Picks the active request from the selected source. Both directions at
    // once is contradictory and is treated as no request.
    function automatic logic [1:0] select_request(
        input logic [1:0] module_choose,
        input logic [1:0] manual_req,
        input logic [1:0] auto_req
    );
        logic [1:0] raw;
        if (module_choose == SRC_NONE)
            raw = REQ_NONE;
        else if (module_choose == SRC_MANUAL)
            raw = manual_req;
        else
            raw = auto_req;
        if (raw == 2'b11)
            raw = REQ_NONE;
        return raw;
    endfunction

endpackage

// File: rtl/indicator_sequencer_blink_timer.sv
// ---------------------------------------------------------------------------
// blink_timer
// Phase timer for the indicator lamps. Counts HALF_PERIOD clocks per phase
// and alternates an on/off phase bit, starting in the on-phase after clear.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   clear     synchronous restart: counter to 0, phase to on
//   run       advance the counter this cycle
//   boundary  high in the last cycle of a phase (phase changes at next edge)
//   phase_on  current phase, 1 = on-phase
//   next_on   phase value that will be registered at the next edge
// ---------------------------------------------------------------------------
module blink_timer #(
    parameter int HALF_PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic boundary,
    output logic phase_on,
    output logic next_on
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count;

    assign boundary = run && (count == LAST);

    // Look-ahead of the phase bit so the lamp registers in the top level can
    // change on the same edge as the phase itself.
    always_comb begin
        next_on = phase_on;
        if (clear)
            next_on = 1'b1;
        else if (boundary)
            next_on = ~phase_on;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            phase_on <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            phase_on <= 1'b1;
        end else if (run) begin
            if (count == LAST) begin
                count    <= '0;
                phase_on <= ~phase_on;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/indicator_sequencer.sv
// ---------------------------------------------------------------------------
// indicator_sequencer
// Turn-indicator sequencer. Blinks the left or right lamp on a turn request,
// guaranteeing at least MIN_FLASH complete flashes (comfort blink), allowing
// direction preemption at phase boundaries and forcing the lamps off when the
// car is not powered and starting/moving.
//
// Optional feature macro: TURN_HAZARD_EN (hazard mode, both lamps blink).
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   power_now      car power present
//   state          one-hot car state (0001/0010/0100/1000)
//   module_choose  request source: 00 none, 01 manual, 1x auto
//   manual_req     manual turn request [1]=left [0]=right
//   auto_req       auto-drive turn request, same encoding
//   hazard_req     hazard request (used only with TURN_HAZARD_EN)
//   left_led       left lamp, registered
//   right_led      right lamp, registered
//   busy           FSM not IDLE
// ---------------------------------------------------------------------------
module indicator_sequencer
    import indicator_pkg::*;
#(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int MIN_FLASH   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_now,
    input  logic [3:0] state,
    input  logic [1:0] module_choose,
    input  logic [1:0] manual_req,
    input  logic [1:0] auto_req,
    input  logic       hazard_req,
    output logic       left_led,
    output logic       right_led,
    output logic       busy
);

    localparam int FW = (MIN_FLASH > 0) ? $clog2(MIN_FLASH + 1) : 1;
    localparam logic [FW-1:0] FLASH_MAX = FW'(MIN_FLASH);

    fsm_state_t    state_q;
    fsm_state_t    state_next;
    logic [1:0]    req;
    logic          enable;
    logic          timer_clear;
    logic          timer_run;
    logic          boundary;
    logic          phase_on;
    logic          next_on;
    logic          left_next;
    logic          right_next;
    logic [FW-1:0] flash_count;
    logic          flash_done;

`ifndef TURN_HAZARD_EN
    logic unused_hazard;
    assign unused_hazard = hazard_req;
`endif

    assign req    = select_request(module_choose, manual_req, auto_req);
    assign enable = power_now && ((state == CAR_STARTING) || (state == CAR_MOVING));

    assign flash_done = (flash_count >= FLASH_MAX);

    // Timer restarts whenever the FSM changes state and is held cleared in
    // IDLE, so every blinking state begins with a full on-phase.
    assign timer_run   = (state_q != IDLE);
    assign timer_clear = (state_next != state_q) || (state_next == IDLE);

    blink_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .run      (timer_run),
        .boundary (boundary),
        .phase_on (phase_on),
        .next_on  (next_on)
    );

    // Next-state logic. Loss of enable wins over everything; an opposite
    // request switches at any phase boundary; a withdrawn request ends the
    // sequence only at the end of an off-phase once enough flashes are done.
    always_comb begin
        state_next = state_q;
        if (!enable) begin
            state_next = IDLE;
        end
`ifdef TURN_HAZARD_EN
        else if (hazard_req && (state_q != HAZARD)) begin
            state_next = HAZARD;
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    if (req == REQ_LEFT)
                        state_next = LEFT;
                    else if (req == REQ_RIGHT)
                        state_next = RIGHT;
                end
                LEFT: begin
                    if (boundary) begin
                        if (req == REQ_RIGHT)
                            state_next = RIGHT;
                        else if (!phase_on && (req != REQ_LEFT) && flash_done)
                            state_next = IDLE;
                    end
                end
                RIGHT: begin
                    if (boundary) begin
                        if (req == REQ_LEFT)
                            state_next = LEFT;
                        else if (!phase_on && (req != REQ_RIGHT) && flash_done)
                            state_next = IDLE;
                    end
                end
`ifdef TURN_HAZARD_EN
                HAZARD: begin
                    if (boundary && !phase_on && !hazard_req) begin
                        if (req == REQ_LEFT)
                            state_next = LEFT;
                        else if (req == REQ_RIGHT)
                            state_next = RIGHT;
                        else
                            state_next = IDLE;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    // Lamp values are derived from the next state and next phase so they are
    // registered on the same edge as the FSM.
    always_comb begin
        left_next  = 1'b0;
        right_next = 1'b0;
        case (state_next)
            LEFT:    left_next  = next_on;
            RIGHT:   right_next = next_on;
`ifdef TURN_HAZARD_EN
            HAZARD: begin
                left_next  = next_on;
                right_next = next_on;
            end
`endif
            default: begin
                left_next  = 1'b0;
                right_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            left_led  <= 1'b0;
            right_led <= 1'b0;
        end else begin
            state_q   <= state_next;
            left_led  <= left_next;
            right_led <= right_next;
        end
    end

    // Flash counter: one count per on->off transition, saturating, restarted
    // together with the phase timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flash_count <= '0;
        else if (timer_clear)
            flash_count <= '0;
        else if (boundary && phase_on && (flash_count != FLASH_MAX))
            flash_count <= flash_count + 1'b1;
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_indicator_sequencer.sv
// ---------------------------------------------------------------------------
// tb_indicator_sequencer
// Directed self-checking bench for indicator_sequencer with HALF_PERIOD=4,
// MIN_FLASH=3. Hazard checks are compiled in when TURN_HAZARD_EN is defined.
// ---------------------------------------------------------------------------
module tb_indicator_sequencer;

    localparam int HP = 4;
    localparam int MF = 3;

    localparam logic [3:0] ST_UNSTARTED = 4'b0001;
    localparam logic [3:0] ST_MOVING    = 4'b0100;
    localparam logic [3:0] ST_OFF       = 4'b1000;

    logic       clk;
    logic       rst;
    logic       power_now;
    logic [3:0] state;
    logic [1:0] module_choose;
    logic [1:0] manual_req;
    logic [1:0] auto_req;
    logic       hazard_req;
    logic       left_led;
    logic       right_led;
    logic       busy;

    int compared_count = 0;
    int mismatch_count = 0;

    indicator_sequencer #(
        .HALF_PERIOD(HP),
        .MIN_FLASH  (MF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_now     (power_now),
        .state         (state),
        .module_choose (module_choose),
        .manual_req    (manual_req),
        .auto_req      (auto_req),
        .hazard_req    (hazard_req),
        .left_led      (left_led),
        .right_led     (right_led),
        .busy          (busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic observed, input logic expected);
        compared_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic pwr, input logic [3:0] st, input logic [1:0] mc,
                                  input logic [1:0] man, input logic [1:0] aut, input logic haz);
        power_now     = pwr;
        state         = st;
        module_choose = mc;
        manual_req    = man;
        auto_req      = aut;
        hazard_req    = haz;
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, ST_UNSTARTED, 2'b00, 2'b00, 2'b00, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus(1'b0, ST_UNSTARTED, 2'b00, 2'b00, 2'b00, 1'b0);
        #1;
        check_output("reset_left",  left_led,  1'b0);
        check_output("reset_right", right_led, 1'b0);
        check_output("reset_busy",  busy,      1'b0);

        // ---- one-cycle manual left request: 3 comfort flashes, 24 busy cycles
        $display("[TB] comfort blink");
        do_reset();
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b10, 2'b00, 1'b0);
        tick();
        check_output("comfort_k0_left", left_led, 1'b1);
        check_output("comfort_k0_busy", busy,     1'b1);
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k < 30; k++) begin
            tick();
            check_output($sformatf("comfort_k%0d_left", k),  left_led,
                         (k < 24) && (((k / HP) % 2) == 0));
            check_output($sformatf("comfort_k%0d_busy", k),  busy, k < 24);
            check_output($sformatf("comfort_k%0d_right", k), right_led, 1'b0);
        end

        // ---- same-direction re-assertion must not restart the count
        $display("[TB] re-assert same direction");
        do_reset();
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b10, 2'b00, 1'b0);
        tick();
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b00, 2'b00, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            if (k == 10) manual_req = 2'b10;
            if (k == 11) manual_req = 2'b00;
            tick();
            if (k == 16) check_output("reassert_k16_left", left_led, 1'b1);
            if (k == 20) check_output("reassert_k20_left", left_led, 1'b0);
            if (k == 23) check_output("reassert_k23_busy", busy, 1'b1);
            if (k == 24) check_output("reassert_k24_busy", busy, 1'b0);
        end

        // ---- auto left held, then right: switch at the edge-8 boundary
        $display("[TB] preemption");
        do_reset();
        apply_stimulus(1'b1, ST_MOVING, 2'b10, 2'b00, 2'b10, 1'b0);
        tick();
        check_output("preempt_k0_left", left_led, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            if (k == 7) auto_req = 2'b01;
            tick();
            if (k == 5) begin
                check_output("preempt_k5_left",  left_led,  1'b0);
                check_output("preempt_k5_right", right_led, 1'b0);
            end
            if (k == 7) begin
                check_output("preempt_k7_left",  left_led,  1'b0);
                check_output("preempt_k7_right", right_led, 1'b0);
            end
            if (k == 8) begin
                check_output("preempt_k8_left",  left_led,  1'b0);
                check_output("preempt_k8_right", right_led, 1'b1);
            end
            if (k == 11) check_output("preempt_k11_right", right_led, 1'b1);
            if (k == 12) check_output("preempt_k12_right", right_led, 1'b0);
            if (k == 16) begin
                check_output("preempt_k16_right", right_led, 1'b1);
                check_output("preempt_k16_left",  left_led,  1'b0);
                check_output("preempt_k16_busy",  busy,      1'b1);
            end
        end

        // ---- power loss mid on-phase, then power back with request held
        $display("[TB] power loss");
        do_reset();
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b10, 2'b00, 1'b0);
        tick();
        tick();
        tick();
        check_output("power_on_left", left_led, 1'b1);
        power_now = 1'b0;
        tick();
        check_output("power_off_left", left_led, 1'b0);
        check_output("power_off_busy", busy,     1'b0);
        power_now = 1'b1;
        tick();
        check_output("power_back_left", left_led, 1'b1);
        check_output("power_back_busy", busy,     1'b1);
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 3)  check_output("power_back_k3_left",  left_led, 1'b1);
            if (k == 4)  check_output("power_back_k4_left",  left_led, 1'b0);
            if (k == 24) check_output("power_held_k24_left", left_led, 1'b1);
            if (k == 24) check_output("power_held_k24_busy", busy,     1'b1);
        end

        // ---- disabled car states and non-requests never start the FSM
        $display("[TB] disabled states");
        do_reset();
        apply_stimulus(1'b1, ST_UNSTARTED, 2'b01, 2'b10, 2'b00, 1'b0);
        for (int k = 0; k < 50; k++) begin
            tick();
            check_output("unstarted_left", left_led, 1'b0);
            check_output("unstarted_busy", busy,     1'b0);
        end
        state = ST_OFF;
        for (int k = 0; k < 50; k++) begin
            tick();
            check_output("powered_off_left", left_led, 1'b0);
            check_output("powered_off_busy", busy,     1'b0);
        end
        state = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_output("non_onehot_busy", busy, 1'b0);
        end
        apply_stimulus(1'b1, ST_MOVING, 2'b10, 2'b10, 2'b11, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_output("both_dirs_busy", busy, 1'b0);
        end
        apply_stimulus(1'b1, ST_MOVING, 2'b00, 2'b10, 2'b10, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_output("no_source_busy", busy, 1'b0);
        end

        // ---- asynchronous reset pulse mid on-phase
        $display("[TB] async reset");
        do_reset();
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b10, 2'b00, 1'b0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_output("async_rst_left", left_led, 1'b0);
        check_output("async_rst_busy", busy,     1'b0);
        tick();
        check_output("rst_held_left", left_led, 1'b0);
        check_output("rst_held_busy", busy,     1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_output("release_busy", busy, 1'b0);
        tick();
        check_output("release_edge_left", left_led, 1'b1);
        check_output("release_edge_busy", busy,     1'b1);

`ifdef TURN_HAZARD_EN
        // ---- hazard during left blink, then release back to IDLE
        $display("[TB] hazard");
        do_reset();
        apply_stimulus(1'b1, ST_MOVING, 2'b01, 2'b10, 2'b00, 1'b0);
        tick();
        tick();
        hazard_req = 1'b1;
        tick();
        check_output("hazard_e2_left",  left_led,  1'b1);
        check_output("hazard_e2_right", right_led, 1'b1);
        for (int k = 3; k <= 10; k++) begin
            if (k == 7) begin
                hazard_req = 1'b0;
                manual_req = 2'b00;
            end
            tick();
            if (k == 5) begin
                check_output("hazard_e5_left",  left_led,  1'b1);
                check_output("hazard_e5_right", right_led, 1'b1);
            end
            if (k == 6) begin
                check_output("hazard_e6_left",  left_led,  1'b0);
                check_output("hazard_e6_right", right_led, 1'b0);
            end
            if (k == 9) check_output("hazard_e9_busy", busy, 1'b1);
            if (k == 10) begin
                check_output("hazard_e10_busy",  busy,      1'b0);
                check_output("hazard_e10_left",  left_led,  1'b0);
                check_output("hazard_e10_right", right_led, 1'b0);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end

endmodule
